// File: rtl/endp_packet_injector.sv
// endp_packet_injector
// Endpoint-side NoC packet transmitter. It serializes packet requests into
// head/body/tail flits on one virtual channel. It keeps one credit counter per
// VC, mirroring the router input buffers, and emits a flit only when the
// target VC holds a credit.
// Optional feature macro: INJECTOR_STATS_EN. When it is defined, the sent
// packet and sent flit counters are live. When it is undefined, both ports
// read 0.
module endp_packet_injector #(
    parameter int V    = 4,
    parameter int B    = 4,
    parameter int DW   = 32,
    parameter int EAw  = 8,
    parameter int LENw = 8,
    localparam int Vw  = (V > 1) ? $clog2(V) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [EAw-1:0]    src_addr,
    input  logic              pkt_req_valid,
    output logic              pkt_req_ready,
    input  logic [EAw-1:0]    pkt_dest,
    input  logic [LENw-1:0]   pkt_len,
    input  logic [Vw-1:0]     pkt_vc,
    input  logic              payload_valid,
    output logic              payload_ready,
    input  logic [DW-1:0]     payload_data,
    output logic [DW+2+V-1:0] flit_out,
    output logic              flit_out_wr,
    input  logic [V-1:0]      credit_in,
    output logic              busy,
    output logic              credit_err,
    output logic [15:0]       sent_pkt_cnt,
    output logic [15:0]       sent_flit_cnt
);

    localparam int CW = $clog2(B + 1);
    localparam logic [CW-1:0]   CRED_MAX = CW'(B);
    localparam logic [CW-1:0]   CRED_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [LENw-1:0] LEN_ONE  = {{(LENw-1){1'b0}}, 1'b1};
    localparam logic [V-1:0]    OH_ONE   = {{(V-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [EAw-1:0]    dest_r;
    logic [LENw-1:0]   len_r;
    logic [Vw-1:0]     vc_r;
    logic [LENw-1:0]   remaining_r;
    logic [LENw-1:0]   remaining_next_s;
    logic [CW-1:0]     credit_r [V];
    logic [DW+2+V-1:0] flit_r;
    logic              flit_wr_r;
    logic              credit_err_r;
    logic              busy_r;

    logic              pkt_req_ready_s;
    logic              payload_ready_s;
    logic              accept_s;
    logic              credit_avail_s;
    logic              emit_s;
    logic              head_s;
    logic              tail_s;
    logic [DW-1:0]     data_s;
    logic [DW-1:0]     head_data_s;
    logic [LENw-1:0]   len_in_s;
    logic [Vw-1:0]     vc_in_s;
    logic [V-1:0]      vc_onehot_s;

    // Zero-length requests become single-flit packets; out-of-range VCs wrap.
    assign len_in_s       = (pkt_len == '0) ? LEN_ONE : pkt_len;
    assign vc_in_s        = Vw'(32'(pkt_vc) % V);
    assign accept_s       = pkt_req_ready_s & pkt_req_valid;
    assign credit_avail_s = (credit_r[vc_r] != '0);
    assign vc_onehot_s    = OH_ONE << vc_r;

    // Head flit payload: dest, source, length, upper bits zero.
    always_comb begin
        head_data_s = '0;
        head_data_s[EAw-1:0]             = dest_r;
        head_data_s[2*EAw-1:EAw]         = src_addr;
        head_data_s[2*EAw+LENw-1:2*EAw]  = len_r;
    end

    // Next-state, emit decision and handshake readiness.
    always_comb begin
        state_next_s     = state_r;
        pkt_req_ready_s  = 1'b0;
        payload_ready_s  = 1'b0;
        emit_s           = 1'b0;
        head_s           = 1'b0;
        tail_s           = 1'b0;
        data_s           = payload_data;
        remaining_next_s = remaining_r;
        case (state_r)
            ST_IDLE: begin
                pkt_req_ready_s = 1'b1;
                if (pkt_req_valid) begin
                    state_next_s = ST_HEAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_HEAD: begin
                if (credit_avail_s) begin
                    emit_s           = 1'b1;
                    head_s           = 1'b1;
                    data_s           = head_data_s;
                    tail_s           = (len_r == LEN_ONE);
                    remaining_next_s = len_r - LEN_ONE;
                    state_next_s     = tail_s ? ST_IDLE : ST_BODY;
                end else begin
                    state_next_s = ST_HEAD;
                end
            end
            ST_BODY: begin
                payload_ready_s = credit_avail_s;
                if (payload_valid && credit_avail_s) begin
                    emit_s           = 1'b1;
                    tail_s           = (remaining_r == LEN_ONE);
                    remaining_next_s = remaining_r - LEN_ONE;
                    state_next_s     = tail_s ? ST_IDLE : ST_BODY;
                end else begin
                    state_next_s = ST_BODY;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, latched packet context and registered flit output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            dest_r      <= '0;
            len_r       <= '0;
            vc_r        <= '0;
            remaining_r <= '0;
            flit_r      <= '0;
            flit_wr_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            busy_r      <= (state_next_s != ST_IDLE);
            remaining_r <= remaining_next_s;
            flit_wr_r   <= emit_s;
            if (accept_s) begin
                dest_r <= pkt_dest;
                len_r  <= len_in_s;
                vc_r   <= vc_in_s;
            end
            if (emit_s) begin
                flit_r <= {head_s, tail_s, vc_onehot_s, data_s};
            end
        end
    end

    // Per-VC credit counters with saturation and sticky overflow error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < V; v++) begin
                credit_r[v] <= CRED_MAX;
            end
            credit_err_r <= 1'b0;
        end else begin
            for (int v = 0; v < V; v++) begin
                if (credit_in[v] && !(emit_s && (vc_r == Vw'(v)))) begin
                    if (credit_r[v] == CRED_MAX) begin
                        credit_err_r <= 1'b1;
                    end else begin
                        credit_r[v] <= credit_r[v] + CRED_ONE;
                    end
                end else if (!credit_in[v] && emit_s && (vc_r == Vw'(v))) begin
                    credit_r[v] <= credit_r[v] - CRED_ONE;
                end
            end
        end
    end

`ifdef INJECTOR_STATS_EN
    logic [15:0] pkt_cnt_r;
    logic [15:0] flit_cnt_r;

    // Completed-packet and emitted-flit counters, wrapping at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_cnt_r  <= 16'd0;
            flit_cnt_r <= 16'd0;
        end else begin
            if (emit_s) begin
                flit_cnt_r <= flit_cnt_r + 16'd1;
            end
            if (emit_s && tail_s) begin
                pkt_cnt_r <= pkt_cnt_r + 16'd1;
            end
        end
    end

    assign sent_pkt_cnt  = pkt_cnt_r;
    assign sent_flit_cnt = flit_cnt_r;
`else
    assign sent_pkt_cnt  = 16'd0;
    assign sent_flit_cnt = 16'd0;
`endif

    assign pkt_req_ready = pkt_req_ready_s;
    assign payload_ready = payload_ready_s;
    assign flit_out      = flit_r;
    assign flit_out_wr   = flit_wr_r;
    assign busy          = busy_r;
    assign credit_err    = credit_err_r;

endmodule

// File: tb/tb_endp_packet_injector.sv
// Self-checking bench for endp_packet_injector: table of single-flit packets
// plus hand-written multi-cycle sequences (credit exhaustion, simultaneous
// credit return, payload bubbles, reset mid-packet, statistics).
module tb_endp_packet_injector;

    logic        clk;
    logic        reset;
    logic [7:0]  src_addr;
    logic        pkt_req_valid;
    logic        pkt_req_ready;
    logic [7:0]  pkt_dest;
    logic [7:0]  pkt_len;
    logic [1:0]  pkt_vc;
    logic        payload_valid;
    logic        payload_ready;
    logic [31:0] payload_data;
    logic [37:0] flit_out;
    logic        flit_out_wr;
    logic [3:0]  credit_in;
    logic        busy;
    logic        credit_err;
    logic [15:0] sent_pkt_cnt;
    logic [15:0] sent_flit_cnt;

    int checks;
    int errors;
    logic [37:0] fq[$];

    endp_packet_injector dut (
        .clk(clk), .reset(reset), .src_addr(src_addr),
        .pkt_req_valid(pkt_req_valid), .pkt_req_ready(pkt_req_ready),
        .pkt_dest(pkt_dest), .pkt_len(pkt_len), .pkt_vc(pkt_vc),
        .payload_valid(payload_valid), .payload_ready(payload_ready),
        .payload_data(payload_data), .flit_out(flit_out),
        .flit_out_wr(flit_out_wr), .credit_in(credit_in), .busy(busy),
        .credit_err(credit_err), .sent_pkt_cnt(sent_pkt_cnt),
        .sent_flit_cnt(sent_flit_cnt)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flit monitor sampling on the falling edge.
    always @(negedge clk) begin
        if (flit_out_wr) fq.push_back(flit_out);
    end

    typedef struct {
        logic [7:0]  dest;
        logic [7:0]  len;
        logic [1:0]  vc;
        logic [37:0] exp_flit;
    } vec_t;

    vec_t tbl[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_pkt(input logic [7:0] d, input logic [7:0] l, input logic [1:0] v);
        pkt_req_valid = 1'b1;
        pkt_dest      = d;
        pkt_len       = l;
        pkt_vc        = v;
        tick();
        pkt_req_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (!busy) break;
            tick();
        end
        check("pkt_done", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        src_addr = 8'h03;
        pkt_req_valid = 1'b0;
        pkt_dest = 8'h00;
        pkt_len = 8'h00;
        pkt_vc = 2'd0;
        payload_valid = 1'b0;
        payload_data = 32'h0;
        credit_in = 4'b0000;

        tbl[0] = '{8'h05, 8'h01, 2'd2, {1'b1, 1'b1, 4'b0100, 32'h0001_0305}};
        tbl[1] = '{8'hA7, 8'h00, 2'd0, {1'b1, 1'b1, 4'b0001, 32'h0001_03A7}};
        tbl[2] = '{8'hFF, 8'h01, 2'd3, {1'b1, 1'b1, 4'b1000, 32'h0001_03FF}};
        tbl[3] = '{8'h00, 8'h01, 2'd1, {1'b1, 1'b1, 4'b0010, 32'h0001_0300}};

        #12 reset = 1'b1;
        tick();

        // Reset state
        check("rst_wr",    {63'd0, flit_out_wr}, 64'd0);
        check("rst_flit",  {26'd0, flit_out}, 64'd0);
        check("rst_busy",  {63'd0, busy}, 64'd0);
        check("rst_err",   {63'd0, credit_err}, 64'd0);
        check("rst_ready", {63'd0, pkt_req_ready}, 64'd1);
        check("rst_pready", {63'd0, payload_ready}, 64'd0);
        check("rst_pcnt",  {48'd0, sent_pkt_cnt}, 64'd0);
        check("rst_fcnt",  {48'd0, sent_flit_cnt}, 64'd0);

        // Table: single-flit packets, flit visible two cycles after acceptance
        for (int i = 0; i < 4; i++) begin
            pkt_req_valid = 1'b1;
            pkt_dest = tbl[i].dest;
            pkt_len  = tbl[i].len;
            pkt_vc   = tbl[i].vc;
            check("tbl_ready", {63'd0, pkt_req_ready}, 64'd1);
            tick();
            pkt_req_valid = 1'b0;
            check("tbl_wr_t1", {63'd0, flit_out_wr}, 64'd0);
            check("tbl_busy",  {63'd0, busy}, 64'd1);
            tick();
            check("tbl_wr_t2", {63'd0, flit_out_wr}, 64'd1);
            check("tbl_flit",  {26'd0, flit_out}, {26'd0, tbl[i].exp_flit});
            tick();
            check("tbl_wr_t3", {63'd0, flit_out_wr}, 64'd0);
        end
        check("cred2_after", {61'd0, dut.credit_r[2]}, 64'd3);
        check("cred0_after", {61'd0, dut.credit_r[0]}, 64'd3);
        credit_in = 4'b1111;
        tick();
        credit_in = 4'b0000;
        check("cred1_back", {61'd0, dut.credit_r[1]}, 64'd4);
        check("cred3_back", {61'd0, dut.credit_r[3]}, 64'd4);
        check("no_err_yet", {63'd0, credit_err}, 64'd0);

        // Credit exhaustion: len 6 on vc 0 with payload always valid
        fq.delete();
        payload_valid = 1'b1;
        payload_data = 32'hA5A5_0001;
        pkt_req_valid = 1'b1; pkt_dest = 8'h11; pkt_len = 8'd6; pkt_vc = 2'd0;
        tick();
        pkt_req_valid = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        check("exh_count4", 64'(fq.size()), 64'd4);
        check("exh_pready", {63'd0, payload_ready}, 64'd0);
        check("exh_busy",   {63'd0, busy}, 64'd1);
        check("exh_wr",     {63'd0, flit_out_wr}, 64'd0);
        credit_in = 4'b0001; tick();
        credit_in = 4'b0000; tick();
        credit_in = 4'b0001; tick();
        credit_in = 4'b0000; tick();
        tick();
        check("exh_count6", 64'(fq.size()), 64'd6);
        check("exh_head",  {26'd0, fq[0]}, {26'd0, 1'b1, 1'b0, 4'b0001, 32'h0006_0311});
        check("exh_body3", {26'd0, fq[3]}, {26'd0, 1'b0, 1'b0, 4'b0001, 32'hA5A5_0001});
        check("exh_body4", {26'd0, fq[4]}, {26'd0, 1'b0, 1'b0, 4'b0001, 32'hA5A5_0001});
        check("exh_tail",  {26'd0, fq[5]}, {26'd0, 1'b0, 1'b1, 4'b0001, 32'hA5A5_0001});
        check("exh_idle",  {63'd0, busy}, 64'd0);
        credit_in = 4'b0001;
        for (int c = 0; c < 4; c++) tick();
        credit_in = 4'b0000;
        check("exh_cred0", {61'd0, dut.credit_r[0]}, 64'd4);

        // Simultaneous emit and return on vc 1, then overflow
        payload_data = 32'h5A5A_0002;
        pkt_req_valid = 1'b1; pkt_dest = 8'h44; pkt_len = 8'd2; pkt_vc = 2'd1;
        tick();
        pkt_req_valid = 1'b0;
        credit_in = 4'b0010;
        tick();
        credit_in = 4'b0000;
        check("sim_cred", {61'd0, dut.credit_r[1]}, 64'd4);
        check("sim_err0", {63'd0, credit_err}, 64'd0);
        tick();
        check("sim_tail", {26'd0, flit_out}, {26'd0, 1'b0, 1'b1, 4'b0010, 32'h5A5A_0002});
        check("sim_cred3", {61'd0, dut.credit_r[1]}, 64'd3);
        payload_valid = 1'b0;
        credit_in = 4'b0010; tick();
        check("sim_err_b", {63'd0, credit_err}, 64'd0);
        tick();
        credit_in = 4'b0000;
        check("sim_err1", {63'd0, credit_err}, 64'd1);
        check("sim_sat",  {61'd0, dut.credit_r[1]}, 64'd4);
        tick(); tick(); tick();
        check("sim_sticky", {63'd0, credit_err}, 64'd1);

        // Payload bubbles: len 3 on vc 3, valid 1,0,1
        pkt_req_valid = 1'b1; pkt_dest = 8'h77; pkt_len = 8'd3; pkt_vc = 2'd3;
        tick();
        pkt_req_valid = 1'b0;
        tick();
        check("bub_head", {26'd0, flit_out}, {26'd0, 1'b1, 1'b0, 4'b1000, 32'h0003_0377});
        payload_valid = 1'b1; payload_data = 32'hB0B0_0001;
        check("bub_pready", {63'd0, payload_ready}, 64'd1);
        tick();
        check("bub_wr1", {63'd0, flit_out_wr}, 64'd1);
        check("bub_b1",  {26'd0, flit_out}, {26'd0, 1'b0, 1'b0, 4'b1000, 32'hB0B0_0001});
        payload_valid = 1'b0;
        tick();
        check("bub_gap", {63'd0, flit_out_wr}, 64'd0);
        check("bub_busy", {63'd0, busy}, 64'd1);
        payload_valid = 1'b1; payload_data = 32'hB0B0_0002;
        tick();
        check("bub_wr2", {63'd0, flit_out_wr}, 64'd1);
        check("bub_tail", {26'd0, flit_out}, {26'd0, 1'b0, 1'b1, 4'b1000, 32'hB0B0_0002});
        payload_valid = 1'b0;
        tick();
        check("bub_end_wr", {63'd0, flit_out_wr}, 64'd0);
        check("bub_idle", {63'd0, busy}, 64'd0);

        // Reset in the middle of a len 5 packet on vc 0
        payload_valid = 1'b1; payload_data = 32'hC0C0_0005;
        pkt_req_valid = 1'b1; pkt_dest = 8'h55; pkt_len = 8'd5; pkt_vc = 2'd0;
        tick();
        pkt_req_valid = 1'b0;
        tick();
        tick();
        check("mid_wr", {63'd0, flit_out_wr}, 64'd1);
        reset = 1'b0;
        #1;
        check("mr_wr",    {63'd0, flit_out_wr}, 64'd0);
        check("mr_flit",  {26'd0, flit_out}, 64'd0);
        check("mr_busy",  {63'd0, busy}, 64'd0);
        check("mr_err",   {63'd0, credit_err}, 64'd0);
        check("mr_ready", {63'd0, pkt_req_ready}, 64'd1);
        #5 reset = 1'b1;
        tick();
        fq.delete();
        check("mr_cred0", {61'd0, dut.credit_r[0]}, 64'd4);
        check("mr_cred3", {61'd0, dut.credit_r[3]}, 64'd4);

        // Clean restart plus statistics: lengths 1, 2, 3
        payload_data = 32'hD0D0_0000;
        send_pkt(8'h22, 8'd1, 2'd0);
        send_pkt(8'h23, 8'd2, 2'd1);
        send_pkt(8'h24, 8'd3, 2'd2);
        tick();
        payload_valid = 1'b0;
        check("st_count", 64'(fq.size()), 64'd6);
        check("st_first", {26'd0, fq[0]}, {26'd0, 1'b1, 1'b1, 4'b0001, 32'h0001_0322});
        check("st_head3", {26'd0, fq[3]}, {26'd0, 1'b1, 1'b0, 4'b0100, 32'h0003_0324});
        check("st_tail3", {26'd0, fq[5]}, {26'd0, 1'b0, 1'b1, 4'b0100, 32'hD0D0_0000});
`ifdef INJECTOR_STATS_EN
        check("st_pcnt", {48'd0, sent_pkt_cnt}, 64'd3);
        check("st_fcnt", {48'd0, sent_flit_cnt}, 64'd6);
`else
        check("st_pcnt", {48'd0, sent_pkt_cnt}, 64'd0);
        check("st_fcnt", {48'd0, sent_flit_cnt}, 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/endp_packet_injector.md
# endp_packet_injector

Endpoint-side packet transmitter that drives a router local input port of the mesh/torus/fmesh/ring/line NoC. It accepts packet requests from the endpoint core and serializes each packet into head, body and tail flits on a selected virtual channel. It holds per-VC credit counters mirroring the router input buffers and only emits a flit when the target VC has a credit. It is the injecting end of the endpoint channel that the NoC top exposes per endpoint.

## Interface

Parameters:
- `V`, 4: number of virtual channels; `Vw` = max(1, log2(V)).
- `B`, 4: router input buffer depth per VC; initial and maximum credit count.
- `DW`, 32: flit payload width; must be ≥ 2*`EAw` + `LENw`.
- `EAw`, 8: endpoint address width.
- `LENw`, 8: packet length field width, in flits.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `src_addr`  in  EAw  this endpoint's address; static after reset.
- `pkt_req_valid`  in  1  packet request present.
- `pkt_req_ready`  out  1  injector idle, request accepted this cycle if valid.
- `pkt_dest`  in  EAw  destination endpoint address.
- `pkt_len`  in  LENw  total flits including head; 0 treated as 1.
- `pkt_vc`  in  Vw  VC index for the whole packet; values ≥ V are taken modulo V.
- `payload_valid`  in  1  body/tail payload word available.
- `payload_ready`  out  1  payload word consumed this cycle.
- `payload_data`  in  DW  body/tail payload.
- `flit_out`  out  DW+2+V  {head, tail, vc_onehot[V-1:0], data[DW-1:0]}.
- `flit_out_wr`  out  1  `flit_out` valid this cycle.
- `credit_in`  in  V  one credit returned per set bit, per cycle.
- `busy`  out  1  state ≠ IDLE.
- `credit_err`  out  1  sticky; credit returned while counter already at B.
- `sent_pkt_cnt`  out  16  packets completed (tail emitted).
- `sent_flit_cnt`  out  16  flits emitted.

## Operation

- FSM states: IDLE, HEAD, BODY.
- IDLE: `pkt_req_ready`=1. On `pkt_req_valid`, latch dest, len (0→1), vc, then go to HEAD.
- HEAD: when credit[vc] > 0, emit the head flit and decrement credit[vc].
  - Head data: [EAw-1:0]=dest, [2EAw-1:EAw]=src_addr, [2EAw+LENw-1:2EAw]=len, upper bits 0.
  - head=1. tail=1 iff len==1; in that case go to IDLE, otherwise go to BODY with remaining=len-1.
  - If there is no credit, stall in HEAD.
- BODY: `payload_ready` = (credit[vc] > 0). When `payload_valid` && `payload_ready`, emit a flit with data=`payload_data`, head=0, tail=(remaining==1), and decrement credit and remaining.
  - When the tail is emitted, go to IDLE.
  - If either condition is false, stall. `flit_out_wr` stays 0 during a stall.
- Credit counters, one per VC, width log2(B+1):
  - Reset to B.
  - Decrement on emit. Increment on `credit_in[v]`.
  - Simultaneous emit and return on the same VC leaves the counter unchanged.
  - A return at B saturates at B and sets `credit_err`.
- vc_onehot = 1 << vc on every flit of the packet.
- Counters `sent_pkt_cnt` and `sent_flit_cnt` wrap modulo 2^16.

## Timing

- Reset (async assert, sync release):
  - FSM=IDLE, all credits=B.
  - `flit_out`=0, `flit_out_wr`=0, `credit_err`=0, counters=0, `busy`=0.
  - `pkt_req_ready`=1 after release.
- `pkt_req_ready` and `payload_ready` are combinational from state/credits. `flit_out` and `flit_out_wr` are registered.
- Request accepted at cycle t → head emit decision at t+1 (if credit) → `flit_out_wr`=1 at t+2.
- Body flits sustain 1 flit/cycle while credits and payload are available. Decision at cycle n → flit visible at n+1.
- A credit returned at cycle n is usable for an emit decision at n+1.
- Back-to-back packets: after the tail decision, IDLE accepts the next request on the following cycle. Minimum gap is 1 idle decision cycle between a tail and the next head.
- Reset mid-packet aborts the packet with no tail emitted. Credits return to B.

## Configuration

- `INJECTOR_STATS_EN`:
  - Defined: `sent_pkt_cnt` and `sent_flit_cnt` are live counters.
  - Undefined: both ports are tied to 0 and the counter logic is absent.
  - All other behaviour is identical either way.

## Test plan

- Single flit: reset, then request dest=0x05, len=1, vc=2, src_addr=0x03 → one flit with head=1, tail=1, vc_onehot=0100, data[23:0]=0x010305, 2 cycles after acceptance; credit[2]=3.
- Credit exhaustion: len=6 on vc=0, payload always valid, no `credit_in` → exactly 4 flits (head + 3 body), then stall in BODY with `payload_ready`=0. Pulse `credit_in[0]` twice → remaining 2 flits emitted, second one tail=1.
- Simultaneous credit: emit on vc=1 in the same cycle as `credit_in[1]`=1 → credit[1] unchanged; extra return at B → `credit_err`=1 and stays 1.
- Payload bubbles: len=3, `payload_valid` toggling 1,0,1 → body flits appear only on valid cycles, tail on the second body flit, no `flit_out_wr` in bubble cycles.
- Reset mid-packet: assert `reset` low during BODY of a len=5 packet → outputs clear immediately, no tail emitted, next packet starts clean with credits=4.
- Stats (with `INJECTOR_STATS_EN`): three packets of len 1, 2, 3 → `sent_pkt_cnt`=3, `sent_flit_cnt`=6. Without the macro, both read 0.
